// File: rtl/fifo_in.sv
// Word-buffering AXI-Stream input FIFO that emits fixed-length bursts of BURST words to a downstream sink.
// Define FIFO_IN_FLUSH_EN to compile in tlast-driven packet flushing with zero-padded partial bursts.
module fifo_in #(
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  input  logic                     dst_ready,
  output logic [31:0]              dout,
  output logic                     data_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int NW = $clog2(BURST + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] beat;
  logic [NW-1:0] n_real;
  logic          flush_pending;
  logic [31:0]   mem [DEPTH];

  logic wr_en, rd_en, start, last_beat;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign s_axis_tready = !full && !flush_pending;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign start         = (state == IDLE) && dst_ready &&
                         ((count >= CW'(BURST)) || (flush_pending && !empty));
  // beats at or past n_real are zero pads of a flushed partial burst
  assign rd_en         = (state == SEND) && (int'(beat) < int'(n_real));
  assign last_beat     = (beat == BW'(BURST - 1));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat       <= '0;
      n_real     <= '0;
      dout       <= '0;
      data_ready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      data_ready <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= SEND;
          beat   <= '0;
          n_real <= (count >= CW'(BURST)) ? NW'(BURST) : NW'(count);
        end
        SEND: begin
          data_ready <= 1'b1;
          dout       <= rd_en ? mem[rd_ptr] : '0;
          beat       <= beat + 1'b1;
          if (last_beat) begin
            state <= GAP;
            beat  <= '0;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_IN_FLUSH_EN
  // a tlast accepted on the SEND-entry edge belongs to the next burst, so set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                flush_pending <= 1'b0;
    else if (wr_en && s_axis_tlast)            flush_pending <= 1'b1;
    else if (start && (count <= CW'(BURST)))   flush_pending <= 1'b0;
  end
`else
  logic unused_tlast;
  assign unused_tlast  = s_axis_tlast;
  assign flush_pending = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_in.sv
// Self-checking bench for fifo_in: a per-cycle vector table, directed corner sequences and a
// randomized run scored against a word-queue model of the burst stream.
module tb_fifo_in;
  localparam int DEPTH = 8;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        dst_ready = 1'b0;
  logic [31:0] dout;
  logic        data_ready;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  fifo_in #(.DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .dst_ready(dst_ready), .dout(dout), .data_ready(data_ready),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output stream capture: every data_ready cycle is one beat; runs_q holds burst lengths.
  logic [31:0] got_q[$];
  int          runs_q[$];
  int          run = 0;
  logic        ovf = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) run = 0;
    else begin
      if (count > 4'(DEPTH)) ovf = 1'b1;
      if (data_ready) begin
        got_q.push_back(dout);
        run++;
      end else if (run != 0) begin
        runs_q.push_back(run);
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    dst_ready = 1'b0;
    repeat (2) step();
    chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd1);
    rst_n = 1'b1;
  endtask

  // Beats after gb must match exp up to the last whole burst; every burst after rb is BURST long.
  task automatic check_stream(input string nm, input int gb, input int rb, input logic [31:0] exp[$]);
    int n, g;
    n = (exp.size() / BURST) * BURST;
    g = got_q.size() - gb;
    chk({nm, "_beats"}, g, n);
    for (int i = 0; i < n && i < g; i++) chk({nm, "_word"}, got_q[gb + i], exp[i]);
    for (int i = rb; i < runs_q.size(); i++) chk({nm, "_burstlen"}, runs_q[i], BURST);
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic        dst;
    logic        e_dr;
    logic [31:0] e_dout;
    logic [3:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [31:0] exp_q[$];
    int gb, rb, k, acc, nz;
    logic prev_dr;
    logic [3:0] prev_cnt;

    // Basic 4-word burst, one vector per clock
    vt[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h00, 4'd1, 1'b1};
    vt[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 32'h00, 4'd2, 1'b1};
    vt[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 32'h00, 4'd3, 1'b1};
    vt[3]  = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h00, 4'd4, 1'b1};
    vt[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 4'd4, 1'b1};
    vt[5]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h11, 4'd3, 1'b1};
    vt[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 4'd2, 1'b1};
    vt[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 4'd1, 1'b1};
    vt[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h44, 4'd0, 1'b1};
    vt[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h44, 4'd0, 1'b1};
    vt[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h44, 4'd0, 1'b1};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      s_axis_tvalid = vt[i].vld;
      s_axis_tdata  = vt[i].d;
      dst_ready     = vt[i].dst;
      step();
      chk($sformatf("vec%0d_data_ready", i), {31'd0, data_ready}, {31'd0, vt[i].e_dr});
      chk($sformatf("vec%0d_dout", i), dout, vt[i].e_dout);
      chk($sformatf("vec%0d_count", i), {28'd0, count}, {28'd0, vt[i].e_cnt});
      chk($sformatf("vec%0d_tready", i), {31'd0, s_axis_tready}, {31'd0, vt[i].e_rdy});
    end
    idle_inputs();
    chk("basic_empty", {31'd0, empty}, 32'd1);

    // Fill to full with the sink stalled, hold a 9th word, then release two bursts
    do_reset();
    gb = got_q.size(); rb = runs_q.size();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h100 + i;
      exp_q.push_back(32'h100 + i);
      step();
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_tready", {31'd0, s_axis_tready}, 32'd0);
    s_axis_tdata = 32'h108;
    repeat (3) step();
    chk("fill_hold_count", {28'd0, count}, 32'd8);
    dst_ready = 1'b1;
    k = 0;
    while (!s_axis_tready && k < 20) begin step(); k++; end
    chk("fill_9th_accept_wait", {31'd0, s_axis_tready}, 32'd1);
    step();
    idle_inputs();
    repeat (16) step();
    check_stream("fill", gb, rb, exp_q);
    chk("fill_leftover_count", {28'd0, count}, 32'd1);

    // Continuous writes while bursting: pointers wrap, count flat within a burst
    do_reset();
    gb = got_q.size(); rb = runs_q.size();
    exp_q.delete();
    dst_ready = 1'b1;
    prev_dr = 1'b0; prev_cnt = '0;
    for (int i = 0; i < 14; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h200 + i;
      if (s_axis_tready) exp_q.push_back(32'h200 + i);
      step();
      if (prev_dr && data_ready) chk("stream_count_flat", {28'd0, count}, {28'd0, prev_cnt});
      prev_dr = data_ready; prev_cnt = count;
    end
    idle_inputs();
    repeat (16) step();
    check_stream("stream", gb, rb, exp_q);

    // Partial packet: flushed with pad when enabled, otherwise parked until a 4th word
    do_reset();
    gb = got_q.size(); rb = runs_q.size();
    dst_ready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hA1; step();
    s_axis_tdata = 32'hA2; step();
    s_axis_tdata = 32'hA3; s_axis_tlast = 1'b1; step();
    idle_inputs();
`ifdef FIFO_IN_FLUSH_EN
    chk("flush_tready_low", {31'd0, s_axis_tready}, 32'd0);
    step();
    chk("flush_tready_after_entry", {31'd0, s_axis_tready}, 32'd1);
    repeat (8) step();
    exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'h0};
    check_stream("flush", gb, rb, exp_q);
    chk("flush_count", {28'd0, count}, 32'd0);
`else
    repeat (6) step();
    chk("noflush_no_beats", got_q.size() - gb, 0);
    chk("noflush_count", {28'd0, count}, 32'd3);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hA4; step();
    idle_inputs();
    repeat (8) step();
    exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    check_stream("noflush", gb, rb, exp_q);
`endif

    // Reset in the middle of a burst, then a clean burst
    do_reset();
    dst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h300 + i;
      step();
    end
    idle_inputs();
    k = 0;
    while (!data_ready && k < 20) begin step(); k++; end
    chk("midrst_burst_start", {31'd0, data_ready}, 32'd1);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data_ready", {31'd0, data_ready}, 32'd0);
    chk("midrst_count", {28'd0, count}, 32'd0);
    step();
    rst_n = 1'b1;
    gb = got_q.size(); rb = runs_q.size();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h51 * (i + 1);
      exp_q.push_back(32'h51 * (i + 1));
      step();
    end
    idle_inputs();
    repeat (10) step();
    check_stream("postrst", gb, rb, exp_q);

    // Randomized traffic against the word-queue model
    do_reset();
    gb = got_q.size(); rb = runs_q.size();
    exp_q.delete();
    acc = 0;
    for (int c = 0; c < 600; c++) begin
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      s_axis_tdata  = $urandom | 32'h1;
      s_axis_tlast  = ($urandom_range(0, 7) == 0);
      dst_ready     = $urandom_range(0, 1) == 1;
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back(s_axis_tdata);
        acc++;
`ifdef FIFO_IN_FLUSH_EN
        if (s_axis_tlast) while (exp_q.size() % BURST != 0) exp_q.push_back(32'h0);
`endif
      end
      step();
    end
    idle_inputs();
    dst_ready = 1'b1;
    repeat (40) step();
    check_stream("rand", gb, rb, exp_q);
    nz = 0;
    for (int i = gb; i < got_q.size(); i++) if (got_q[i] != 0) nz++;
    chk("rand_leftover_count", {28'd0, count}, acc - nz);
    chk("count_bound", {31'd0, ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_in.md
FIFO_IN -- requirements
Module: fifo_in

Interface
REQ-001 Parameter DEPTH, default 8, internal buffer depth in 32-bit words; power of two, >= BURST.
REQ-002 Parameter BURST, default 4, words per output burst.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  input  32  AXI-Stream slave data.
REQ-006 s_axis_tvalid  input  1  upstream word valid.
REQ-007 s_axis_tlast  input  1  marks final word of a packet.
REQ-008 s_axis_tready  output  1  block accepts a word this cycle.
REQ-009 dst_ready  input  1  downstream can take a full burst.
REQ-010 dout  output  32  burst data word, registered.
REQ-011 data_ready  output  1  dout valid; high for exactly BURST consecutive cycles per burst.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 count  output  clog2(DEPTH)+1  words currently buffered.

Function
REQ-015 A word SHALL be written at wr_ptr on any cycle with s_axis_tvalid && s_axis_tready; wr_ptr wraps modulo DEPTH.
REQ-016 s_axis_tready SHALL be !full && !flush_pending, decoded from registered state only (no combinational path from tvalid).
REQ-017 FSM states SHALL be IDLE, SEND, GAP; encoding 2 bits; illegal encodings go to IDLE.
REQ-018 IDLE -> SEND when dst_ready && (count >= BURST || (flush_pending && count > 0)).
REQ-019 SEND SHALL last exactly BURST cycles via beat counter 0..BURST-1; each cycle dout <= mem[rd_ptr], data_ready <= 1, rd_ptr increments (wraps), count decrements, for real beats.
REQ-020 First data_ready high SHALL occur the cycle after the IDLE->SEND decision; dst_ready is sampled only in IDLE and ignored during SEND/GAP.
REQ-021 After the last beat SEND -> GAP for one cycle (data_ready=0, dout held), then GAP -> IDLE.
REQ-022 Simultaneous write and read in one cycle SHALL leave count unchanged and both pointers advance.
REQ-023 Write attempted when full SHALL be refused (tready low); no overwrite, no pointer move.
REQ-024 Outside SEND, data_ready SHALL be 0 and dout SHALL hold its last value.
REQ-025 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, wr_ptr=rd_ptr=0, count=0, beat=0, flush_pending=0, dout=0, data_ready=0; memory contents are not reset.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately; buffered words are discarded.
REQ-028 First acceptance after reset release SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-029 Macro FIFO_IN_FLUSH_EN SHALL compile in packet flushing.
REQ-030 With FIFO_IN_FLUSH_EN: accepting a word with s_axis_tlast=1 sets flush_pending; a SEND entered with count < BURST sends count real words then BURST-count zero beats (data_ready still high, count/rd_ptr not advanced on pad beats); flush_pending clears on SEND entry when count <= BURST.
REQ-031 Without FIFO_IN_FLUSH_EN: s_axis_tlast is ignored, flush_pending is constant 0, partial bursts stay buffered until BURST words exist.

Verification
REQ-032 Reset then 4 words 0x11..0x44 with dst_ready=1 -> data_ready high 4 cycles, dout 0x11,0x22,0x33,0x44, then 1 GAP cycle, empty=1.
REQ-033 8 words with dst_ready=0 -> full=1, tready=0, 9th word held; raise dst_ready -> two bursts in order, 1-cycle gap between, no loss.
REQ-034 Continuous tvalid during SEND -> writes and reads same cycle, count constant, wrap of both pointers past 7 -> 0 correct data order.
REQ-035 FLUSH_EN: 3 words 0xA1,0xA2,0xA3 with tlast on 0xA3 -> burst 0xA1,0xA2,0xA3,0x0; tready low from tlast acceptance until SEND entry.
REQ-036 No FLUSH_EN: same stimulus -> no burst, count=3; 4th word 0xA4 -> burst 0xA1..0xA4.
REQ-037 rst_n low during beat 2 of a burst -> data_ready=0 and count=0 asynchronously; after release, new 4-word burst correct.
